decrypt_cfg_regfile: RTL

- Parametrised successor to the decryption register file.
- Holds the algorithm select plus NUM_KEYS key registers, all double-buffered as shadow and active copies.
- A software write to CTRL.COMMIT transfers shadow to active atomically. The transfer is deferred while the decryption engine reports busy.
- Adds a one-cycle done/error handshake, a status register and a saturating error counter. Sits between the host bus and the decryption datapath.

---
 rtl/decrypt_cfg_pkg.sv | 31 +++
 rtl/cfg_shadow_reg.sv | 35 +++
 rtl/decrypt_cfg_regfile.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/decrypt_cfg_pkg.sv
// Shared constants and types for the decryption configuration register file.
package decrypt_cfg_pkg;

  // Register map (byte addresses, registers on even addresses)
  localparam int unsigned ADDR_SELECT   = 32'h00;
  localparam int unsigned ADDR_CTRL     = 32'h02;
  localparam int unsigned ADDR_STATUS   = 32'h04;
  localparam int unsigned ADDR_KEY_BASE = 32'h10;

  // CTRL bit indices
  localparam int unsigned CTRL_COMMIT_BIT  = 0;
  localparam int unsigned CTRL_CLR_ERR_BIT = 1;

  // STATUS bit indices
  localparam int unsigned STATUS_PENDING_BIT = 0;
  localparam int unsigned STATUS_BUSY_BIT    = 1;
  localparam int unsigned STATUS_ERR_LSB     = 8;

  localparam int unsigned ERR_CNT_W = 8;

  typedef enum logic {
    AccOk  = 1'b0,
    AccErr = 1'b1
  } acc_res_e;

  // Saturating increment of the error counter
  function automatic logic [ERR_CNT_W-1:0] err_cnt_inc(input logic [ERR_CNT_W-1:0] cnt);
    return (cnt == '1) ? cnt : cnt + ERR_CNT_W'(1);
  endfunction

endpackage

// File: rtl/cfg_shadow_reg.sv
// One double-buffered configuration register: software writes the shadow copy,
// a commit copies shadow into the active copy seen by the datapath.
module cfg_shadow_reg
  import decrypt_cfg_pkg::*;
#(
  parameter int unsigned W   = 16,
  parameter logic [W-1:0] RST = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_we,
  input  logic [W-1:0] i_wdata,
  input  logic         i_commit,
  output logic [W-1:0] o_shadow,
  output logic [W-1:0] o_active
);

  logic [W-1:0] r_shadow;
  logic [W-1:0] r_active;

  // Commit samples the pre-edge shadow, so a same-edge write stays in shadow only
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shadow <= RST;
      r_active <= RST;
    end else begin
      if (i_commit) r_active <= r_shadow;
      if (i_we)     r_shadow <= i_wdata;
    end
  end

  assign o_shadow = r_shadow;
  assign o_active = r_active;

endmodule

// File: rtl/decrypt_cfg_regfile.sv
// Decryption configuration register file: double-buffered SELECT and KEY
// registers, busy-deferred commit, one-cycle done/error handshake, status
// register and saturating error counter.
module decrypt_cfg_regfile
  import decrypt_cfg_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned NUM_KEYS = 3,
  parameter int unsigned SEL_W    = 2,
  parameter logic [NUM_KEYS*DATA_W-1:0] KEY_RST = {16'h0002, 16'hFFFF, 16'h0000}
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [ADDR_W-1:0]            i_addr,
  input  logic                         i_read,
  input  logic                         i_write,
  input  logic [DATA_W-1:0]            i_wdata,
  output logic [DATA_W-1:0]            o_rdata,
  output logic                         o_done,
  output logic                         o_error,
  input  logic                         i_engine_busy,
  output logic [SEL_W-1:0]             o_select,
  output logic [NUM_KEYS*DATA_W-1:0]   o_keys,
  output logic                         o_cfg_update
);

  // Address decode
  logic                w_hit_sel;
  logic                w_hit_ctrl;
  logic                w_hit_status;
  logic [NUM_KEYS-1:0] w_hit_key;
  logic                w_mapped;

  assign w_hit_sel    = (i_addr == ADDR_W'(ADDR_SELECT));
  assign w_hit_ctrl   = (i_addr == ADDR_W'(ADDR_CTRL));
  assign w_hit_status = (i_addr == ADDR_W'(ADDR_STATUS));

  // Key addresses are all even, so odd addresses fall out as unmapped
  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key_hit
    assign w_hit_key[gi] = (i_addr == ADDR_W'(ADDR_KEY_BASE + 2 * gi));
  end

  assign w_mapped = w_hit_sel | w_hit_ctrl | w_hit_status | (|w_hit_key);

  // Access classification
  logic     w_req;
  acc_res_e w_res;
  logic     w_err;
  logic     w_wr_ok;
  logic     w_rd_ok;

  assign w_req = i_read | i_write;
  assign w_res = (w_req && ((i_read && i_write) || !w_mapped ||
                            (i_write && w_hit_status) || (i_read && w_hit_ctrl))) ? AccErr : AccOk;
  assign w_err   = (w_res == AccErr);
  assign w_wr_ok = i_write & ~w_err;
  assign w_rd_ok = i_read & ~w_err;

  // Commit control: a COMMIT with the engine idle transfers on the same edge
  logic r_pending;
  logic w_commit_wr;
  logic w_clr_req;
  logic w_xfer;
  logic w_pending_d;

  assign w_commit_wr = w_wr_ok & w_hit_ctrl & i_wdata[CTRL_COMMIT_BIT];
  assign w_clr_req   = i_write & w_hit_ctrl & i_wdata[CTRL_CLR_ERR_BIT];
  assign w_xfer      = (r_pending | w_commit_wr) & ~i_engine_busy;
  assign w_pending_d = w_xfer ? 1'b0 : (r_pending | w_commit_wr);

  // Shadow/active storage
  logic [SEL_W-1:0]           w_sel_shadow;
  logic [NUM_KEYS*DATA_W-1:0] w_key_shadow;

  cfg_shadow_reg #(
    .W   (SEL_W),
    .RST ('0)
  ) u_sel_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_we     (w_wr_ok & w_hit_sel),
    .i_wdata  (i_wdata[SEL_W-1:0]),
    .i_commit (w_xfer),
    .o_shadow (w_sel_shadow),
    .o_active (o_select)
  );

  for (genvar gk = 0; gk < NUM_KEYS; gk++) begin : g_key_reg
    cfg_shadow_reg #(
      .W   (DATA_W),
      .RST (KEY_RST[gk*DATA_W +: DATA_W])
    ) u_key_reg (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_we     (w_wr_ok & w_hit_key[gk]),
      .i_wdata  (i_wdata),
      .i_commit (w_xfer),
      .o_shadow (w_key_shadow[gk*DATA_W +: DATA_W]),
      .o_active (o_keys[gk*DATA_W +: DATA_W])
    );
  end

  // Error counter next state: an error beats a same-edge clear, leaving one error counted
  logic [ERR_CNT_W-1:0] r_err_cnt;
  logic [ERR_CNT_W-1:0] w_err_cnt_d;

  always_comb begin
    w_err_cnt_d = r_err_cnt;
    if (w_err) begin
      w_err_cnt_d = w_clr_req ? ERR_CNT_W'(1) : err_cnt_inc(r_err_cnt);
    end else if (w_clr_req) begin
      w_err_cnt_d = '0;
    end
  end

  // Read data mux over shadow copies and status
  logic [DATA_W-1:0] w_rd_val;

  always_comb begin
    w_rd_val = '0;
    if (w_hit_sel) w_rd_val = DATA_W'(w_sel_shadow);
    if (w_hit_status) begin
      w_rd_val[STATUS_PENDING_BIT]              = r_pending;
      w_rd_val[STATUS_BUSY_BIT]                 = i_engine_busy;
      w_rd_val[STATUS_ERR_LSB +: ERR_CNT_W]     = r_err_cnt;
    end
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (w_hit_key[k]) w_rd_val = w_key_shadow[k*DATA_W +: DATA_W];
    end
  end

  // Handshake outputs, pending flag and error counter
  logic [DATA_W-1:0] r_rdata;
  logic              r_done;
  logic              r_error;
  logic              r_cfg_update;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pending    <= 1'b0;
      r_err_cnt    <= '0;
      r_rdata      <= '0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_cfg_update <= 1'b0;
    end else begin
      r_pending    <= w_pending_d;
      r_err_cnt    <= w_err_cnt_d;
      r_rdata      <= w_rd_ok ? w_rd_val : '0;
      r_done       <= w_req;
      r_error      <= w_err;
      r_cfg_update <= w_xfer;
    end
  end

  assign o_rdata      = r_rdata;
  assign o_done       = r_done;
  assign o_error      = r_error;
  assign o_cfg_update = r_cfg_update;

endmodule
